// File: rtl/oa22_bist_ctrl.sv
// BIST sequencer for one OA22 cell: sweeps all 16 input vectors, checks Z against (A|B)&(C|D).
// Optional first-failure capture (FAIL_VLD/FAIL_VEC) is enabled by defining OA22_BIST_FAILLOG_EN.
module oa22_bist_ctrl #(
    parameter int unsigned PASSES = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    input  logic             Z_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT
`ifdef OA22_BIST_FAILLOG_EN
    ,
    output logic             FAIL_VLD,
    output logic [3:0]       FAIL_VEC
`endif
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PASSES - 1);
    localparam logic [3:0]       VEC_LAST = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         vec_q, vec_d;
    logic [PC_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         abcd_q, abcd_d;
    logic               exp_c;
    logic               mis_c;
`ifdef OA22_BIST_FAILLOG_EN
    logic               fail_vld_q, fail_vld_d;
    logic [3:0]         fail_vec_q, fail_vec_d;
`endif

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pass_cnt_d = pass_cnt_q;
        settle_d   = settle_q;
        err_d      = err_q;
        pass_d     = pass_q;
`ifdef OA22_BIST_FAILLOG_EN
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
`endif
        exp_c = (vec_q[3] | vec_q[2]) & (vec_q[1] | vec_q[0]);
        mis_c = (Z_IN != exp_c);

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    err_d      = '0;
                    pass_d     = 1'b0;
                    vec_d      = 4'h0;
                    pass_cnt_d = '0;
`ifdef OA22_BIST_FAILLOG_EN
                    fail_vld_d = 1'b0;
                    fail_vec_d = 4'h0;
`endif
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = '0;
                state_d  = (SETTLE == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (settle_q == SET_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_CHECK: begin
                if (mis_c) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
`ifdef OA22_BIST_FAILLOG_EN
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_vec_d = vec_q;
                    end
`endif
                end
                if (vec_q != VEC_LAST) begin
                    vec_d   = vec_q + 4'd1;
                    state_d = S_DRIVE;
                end else if (pass_cnt_q != PC_LAST) begin
                    vec_d      = 4'h0;
                    pass_cnt_d = pass_cnt_q + PC_W'(1);
                    state_d    = S_DRIVE;
                end else begin
                    // Verdict includes the mismatch (if any) on this final vector.
                    pass_d  = (err_d == '0);
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
        abcd_d = ((state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK)) ? vec_d : 4'h0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            vec_q      <= 4'h0;
            pass_cnt_q <= '0;
            settle_q   <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abcd_q     <= 4'h0;
`ifdef OA22_BIST_FAILLOG_EN
            fail_vld_q <= 1'b0;
            fail_vec_q <= 4'h0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pass_cnt_q <= pass_cnt_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abcd_q     <= abcd_d;
`ifdef OA22_BIST_FAILLOG_EN
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
`endif
        end
    end

    assign A       = abcd_q[3];
    assign B       = abcd_q[2];
    assign C       = abcd_q[1];
    assign D       = abcd_q[0];
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PASS    = pass_q;
    assign ERR_CNT = err_q;
`ifdef OA22_BIST_FAILLOG_EN
    assign FAIL_VLD = fail_vld_q;
    assign FAIL_VEC = fail_vec_q;
`endif

endmodule

// File: tb/tb_oa22_bist_ctrl.sv
// Self-checking bench for oa22_bist_ctrl: positional run model plus directed literal checks.
module tb_oa22_bist_ctrl;

    localparam int S    = 1;
    localparam int P    = 2;
    localparam int SPAN = S + 2;
    localparam int N    = P * 16 * SPAN;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       Z_IN;
    logic       A, B, C, D, BUSY, DONE, PASS;
    logic [7:0] ERR_CNT;
    int         zmode = 0;

    logic       s_start = 1'b0;
    logic       s_a, s_b, s_c, s_d, s_busy, s_done, s_pass;
    logic [3:0] s_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef OA22_BIST_FAILLOG_EN
    logic       FAIL_VLD, s_fv;
    logic [3:0] FAIL_VEC, s_fvec;
`endif

    always #5 CLK = ~CLK;

    // The cell under test: golden OA22, stuck-at-0 or stuck-at-1.
    assign Z_IN = (zmode == 0) ? ((A | B) & (C | D)) : ((zmode == 1) ? 1'b0 : 1'b1);

    oa22_bist_ctrl u_dut (
        .CLK(CLK), .RST(RST), .START(START),
        .A(A), .B(B), .C(C), .D(D), .Z_IN(Z_IN),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT)
`ifdef OA22_BIST_FAILLOG_EN
        , .FAIL_VLD(FAIL_VLD), .FAIL_VEC(FAIL_VEC)
`endif
    );

    oa22_bist_ctrl #(.PASSES(4), .SETTLE(0), .ERR_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .START(s_start),
        .A(s_a), .B(s_b), .C(s_c), .D(s_d), .Z_IN(1'b1),
        .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .ERR_CNT(s_err)
`ifdef OA22_BIST_FAILLOG_EN
        , .FAIL_VLD(s_fv), .FAIL_VEC(s_fvec)
`endif
    );

    function automatic logic golden(input logic [3:0] v);
        return (v[3] | v[2]) & (v[1] | v[0]);
    endfunction

    function automatic logic zval(input int mode, input logic [3:0] v);
        if (mode == 0) return golden(v);
        return (mode == 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_pos = -1 idle, 0..N-1 cycles into the run, N = finish cycle.
    int         m_pos  = -1;
    logic [7:0] m_err  = 8'h0;
    logic       m_pass = 1'b0;
    logic       m_fv   = 1'b0;
    logic [3:0] m_fvec = 4'h0;

    always @(posedge CLK or posedge RST) begin : model
        int         p;
        logic [7:0] e;
        logic       pa, fv;
        logic [3:0] fvec, v;
        p = m_pos; e = m_err; pa = m_pass; fv = m_fv; fvec = m_fvec;
        if (RST) begin
            p = -1; e = 8'h0; pa = 1'b0; fv = 1'b0; fvec = 4'h0;
        end else if (p < 0) begin
            if (START) begin
                p = 0; e = 8'h0; pa = 1'b0; fv = 1'b0; fvec = 4'h0;
            end
        end else if (p < N) begin
            if ((p % SPAN) == SPAN - 1) begin
                v = 4'(p / SPAN);
                if (zval(zmode, v) != golden(v)) begin
                    if (e != 8'hFF) e = e + 8'd1;
                    if (!fv) begin
                        fv = 1'b1;
                        fvec = v;
                    end
                end
            end
            p = p + 1;
            if (p == N) pa = (e == 8'h0);
        end else begin
            p = -1;
        end
        m_pos <= p; m_err <= e; m_pass <= pa; m_fv <= fv; m_fvec <= fvec;
    end

    always @(negedge CLK) begin : compare
        logic [3:0] exp_abcd;
        exp_abcd = (m_pos >= 0 && m_pos < N) ? 4'(m_pos / SPAN) : 4'h0;
        check("busy", 32'(BUSY), 32'(m_pos >= 0));
        check("done", 32'(DONE), 32'(m_pos == N));
        check("abcd", 32'({A, B, C, D}), 32'(exp_abcd));
        check("err_cnt", 32'(ERR_CNT), 32'(m_err));
        check("pass", 32'(PASS), 32'(m_pass));
`ifdef OA22_BIST_FAILLOG_EN
        check("fail_vld", 32'(FAIL_VLD), 32'(m_fv));
        check("fail_vec", 32'(FAIL_VEC), 32'(m_fvec));
`endif
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Pulse START, then follow the run until BUSY drops; e counts edges from the accepting edge.
    task automatic run_once(output int busy_n, output int done_edge, output int done_n);
        bit ended;
        ended = 1'b0;
        busy_n = 0; done_edge = 0; done_n = 0;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int e = 1; e < 400; e++) begin
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                if (done_edge == 0) done_edge = e;
            end
            if (!BUSY) begin
                ended = 1'b1;
                break;
            end
            step();
        end
        check("run_terminates", 32'(ended), 32'd1);
    endtask

    task automatic expect_full_run(input string name);
        int bn, de, dn;
        run_once(bn, de, dn);
        check({name, "_busy_cycles"}, 32'(bn), 32'd97);
        check({name, "_done_edge"}, 32'(de), 32'd97);
        check({name, "_done_pulses"}, 32'(dn), 32'd1);
    endtask

    initial begin
        int  first_done, last_done, done_cnt, bn, de;
        bit  found;

        repeat (3) step();
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_pass", 32'(PASS), 32'd0);
        check("rst_err", 32'(ERR_CNT), 32'd0);
        check("rst_abcd", 32'({A, B, C, D}), 32'd0);
        RST = 1'b0;
        step();

        zmode = 0;
        expect_full_run("golden1");
        check("golden1_err", 32'(ERR_CNT), 32'd0);
        check("golden1_pass", 32'(PASS), 32'd1);

        zmode = 1;
        expect_full_run("stuck0");
        check("stuck0_err", 32'(ERR_CNT), 32'd18);
        check("stuck0_pass", 32'(PASS), 32'd0);
`ifdef OA22_BIST_FAILLOG_EN
        check("stuck0_fail_vld", 32'(FAIL_VLD), 32'd1);
        check("stuck0_fail_vec", 32'(FAIL_VEC), 32'h5);
`endif

        zmode = 0;
        expect_full_run("golden2");
        check("golden2_pass", 32'(PASS), 32'd1);
`ifdef OA22_BIST_FAILLOG_EN
        check("golden2_fail_vld", 32'(FAIL_VLD), 32'd0);
`endif

        zmode = 2;
        expect_full_run("stuck1");
        check("stuck1_err", 32'(ERR_CNT), 32'd14);
        check("stuck1_pass", 32'(PASS), 32'd0);

        // Abort on reset while vector 5 is applied in the first pass.
        zmode = 0;
        found = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ({A, B, C, D} == 4'h5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("abort_reached_vec5", 32'(found), 32'd1);
        RST = 1'b1;
        #1;
        check("abort_abcd", 32'({A, B, C, D}), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_err", 32'(ERR_CNT), 32'd0);
        step();
        step();
        check("abort_done_held", 32'(DONE), 32'd0);
        RST = 1'b0;
        step();
        expect_full_run("after_abort");

        // START held high: runs accepted at edges 1, 99, 197.
        first_done = 0; last_done = 0; done_cnt = 0;
        START = 1'b1;
        for (int e = 1; e <= 294; e++) begin
            step();
            if (DONE) begin
                done_cnt++;
                if (first_done == 0) first_done = e;
                last_done = e;
            end
        end
        START = 1'b0;
        check("held_done_count", 32'(done_cnt), 32'd3);
        check("held_first_done", 32'(first_done), 32'd97);
        check("held_last_done", 32'(last_done), 32'd293);
        step();
        check("held_idle_after", 32'(BUSY), 32'd0);

        // Saturation instance: PASSES=4, SETTLE=0, ERR_W=4, Z stuck at 1.
        bn = 0; de = 0; found = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int e = 1; e < 400; e++) begin
            if (s_busy) bn++;
            if (s_done && de == 0) de = e;
            if (!s_busy) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("sat_terminates", 32'(found), 32'd1);
        check("sat_busy_cycles", 32'(bn), 32'd129);
        check("sat_done_edge", 32'(de), 32'd129);
        check("sat_err", 32'(s_err), 32'd15);
        check("sat_pass", 32'(s_pass), 32'd0);
        check("sat_abcd_idle", 32'({s_a, s_b, s_c, s_d}), 32'd0);
`ifdef OA22_BIST_FAILLOG_EN
        check("sat_fail_vld", 32'(s_fv), 32'd1);
        check("sat_fail_vec", 32'(s_fvec), 32'd0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
